// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg
//   Shared definitions for the SR flip-flop bank:
//   - sr_mode_e : how a channel resolves simultaneous filtered set and reset
//   - DEB_MAX   : deepest supported debounce filter, in clock cycles
//   - DEB_CW    : width of the per-bit debounce stability counter
//   - resolve() : single-channel next-state rule
package sr_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,  // S&R keeps the current state
    MODE_SET  = 2'd1,  // S&R forces 1
    MODE_RST  = 2'd2,  // S&R forces 0
    MODE_TOG  = 2'd3   // S&R inverts the current state
  } sr_mode_e;

  localparam int unsigned DEB_MAX = 15;
  localparam int unsigned DEB_CW  = $clog2(DEB_MAX + 1);

  // Next state of one channel from its filtered set/reset and current state.
  function automatic logic resolve(sr_mode_e mode, logic s, logic r, logic q);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b00: nxt = q;
      2'b11: begin
        case (mode)
          MODE_HOLD: nxt = q;
          MODE_SET:  nxt = 1'b1;
          MODE_RST:  nxt = 1'b0;
          MODE_TOG:  nxt = ~q;
          default:   nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_deb.sv
// sr_deb
//   Single-bit debounce filter. The filtered output follows the raw input
//   only after the raw level has differed from it on DEB consecutive rising
//   edges; it changes on the DEB-th such edge. Any edge where raw agrees with
//   the filtered value restarts the count. DEB = 0 is a plain wire.
// Ports
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (filtered value and count to 0)
//   d_i   : raw input
//   f_o   : filtered output
module sr_deb
  import sr_bank_pkg::*;
#(
  parameter int DEB = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic f_o
);

  generate
    if (DEB == 0) begin : g_bypass
      assign f_o = d_i;

      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
    end else begin : g_filt
      localparam logic [DEB_CW-1:0] DEB_L = DEB_CW'(DEB);

      logic              f_q, f_d;
      logic [DEB_CW-1:0] cnt_q, cnt_d;

      always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (d_i != f_q) begin
          // Commit on the DEB-th disagreeing edge; the count then starts over.
          if (cnt_q + 1'b1 == DEB_L) begin
            f_d = d_i;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          f_q   <= 1'b0;
          cnt_q <= '0;
        end else begin
          f_q   <= f_d;
          cnt_q <= cnt_d;
        end
      end

      assign f_o = f_q;
    end
  endgenerate

endmodule

// File: rtl/sr_ff_bank.sv
// sr_ff_bank
//   Bank of N independent SR flip-flops with per-input debounce, configurable
//   S&R resolution, registered edge pulses and a saturating conflict counter.
// Parameters
//   N    : channel count (1..32)
//   MODE : S&R resolution, see sr_mode_e (0 hold, 1 set, 2 reset, 3 toggle)
//   DEB  : debounce depth in cycles (0..15, 0 = unfiltered)
//   CNTW : conflict counter width
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset, overrides every input
//   S, R         : raw per-channel set / reset requests
//   clr_cnt      : synchronous clear of conflict_cnt (wins over increment)
//   Q, Qn        : registered channel state and its complement
//   rise, fall   : one-cycle pulses in the cycle Q shows a 0->1 / 1->0 change
//   conflict     : some channel saw filtered S&R on the previous edge
//   conflict_cnt : saturating count of edges where conflict was high
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = 1,
  parameter int DEB  = 2,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    S,
  input  logic [N-1:0]    R,
  input  logic            clr_cnt,
  output logic [N-1:0]    Q,
  output logic [N-1:0]    Qn,
  output logic [N-1:0]    rise,
  output logic [N-1:0]    fall,
  output logic            conflict,
  output logic [CNTW-1:0] conflict_cnt
);

  localparam sr_mode_e MODE_E = sr_mode_e'(2'(MODE));

  logic [N-1:0]    sf, rf;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    rise_q, rise_d;
  logic [N-1:0]    fall_q, fall_d;
  logic            conf_q, conf_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      sr_deb #(.DEB(DEB)) u_deb_s (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (S[gi]),
        .f_o   (sf[gi])
      );
      sr_deb #(.DEB(DEB)) u_deb_r (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (R[gi]),
        .f_o   (rf[gi])
      );
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    for (int unsigned i = 0; i < N; i++) begin
      q_d[i] = resolve(MODE_E, sf[i], rf[i], q_q[i]);
    end
    // Pulses are registered with Q so they line up with the new value.
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
    conf_d = |(sf & rf);

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      conf_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q            = q_q;
  assign Qn           = ~q_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank
//   Four sr_ff_bank instances with different MODE/DEB/CNTW share one stimulus.
//   A run-length based reference model predicts every output each cycle;
//   directed sequences add literal expectations, then random traffic follows.
module tb_sr_ff_bank;

  localparam int NI = 4;
  localparam int P_MODE [NI] = '{1, 3, 2, 0};
  localparam int P_DEB  [NI] = '{2, 0, 2, 1};
  localparam int P_CNTW [NI] = '{8, 2, 8, 3};

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] S       = '0;
  logic [7:0] R       = '0;
  logic       clr_cnt = 1'b0;

  logic [NI-1:0][7:0] q_w, qn_w, rise_w, fall_w, cnt_w;
  logic [NI-1:0]      conf_w;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      logic [P_CNTW[g]-1:0] cnt_l;
      sr_ff_bank #(
        .N    (8),
        .MODE (P_MODE[g]),
        .DEB  (P_DEB[g]),
        .CNTW (P_CNTW[g])
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .S            (S),
        .R            (R),
        .clr_cnt      (clr_cnt),
        .Q            (q_w[g]),
        .Qn           (qn_w[g]),
        .rise         (rise_w[g]),
        .fall         (fall_w[g]),
        .conflict     (conf_w[g]),
        .conflict_cnt (cnt_l)
      );
      assign cnt_w[g] = 8'(cnt_l);
    end
  endgenerate

  task automatic chk(input string name, input int k, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q [NI];
  logic [7:0] m_rise [NI];
  logic [7:0] m_fall [NI];
  logic [7:0] m_fs [NI];
  logic [7:0] m_fr [NI];
  logic       m_conf [NI];
  int         m_cnt [NI];
  int         s_len [8];
  int         r_len [8];
  logic       s_val [8];
  logic       r_val [8];
  logic [7:0] us, ur, nq;
  bit         m_valid = 1'b0;

  function automatic logic model_next(int mode, logic s, logic r, logic q);
    if (s && !r) return 1'b1;
    if (!s && r) return 1'b0;
    if (!s && !r) return q;
    if (mode == 0) return q;
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return !q;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_q[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
        m_fs[k] = '0; m_fr[k] = '0; m_conf[k] = 1'b0; m_cnt[k] = 0;
      end
      for (int i = 0; i < 8; i++) begin
        s_len[i] = 0; r_len[i] = 0; s_val[i] = 1'b0; r_val[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      // Length of the current run of identical raw samples since reset.
      for (int i = 0; i < 8; i++) begin
        if (s_len[i] > 0 && s_val[i] == S[i]) s_len[i]++;
        else begin s_val[i] = S[i]; s_len[i] = 1; end
        if (r_len[i] > 0 && r_val[i] == R[i]) r_len[i]++;
        else begin r_val[i] = R[i]; r_len[i] = 1; end
      end
      for (int k = 0; k < NI; k++) begin
        us = (P_DEB[k] == 0) ? S : m_fs[k];
        ur = (P_DEB[k] == 0) ? R : m_fr[k];
        for (int i = 0; i < 8; i++) nq[i] = model_next(P_MODE[k], us[i], ur[i], m_q[k][i]);
        if (clr_cnt) m_cnt[k] = 0;
        else if (m_conf[k] && m_cnt[k] < (1 << P_CNTW[k]) - 1) m_cnt[k]++;
        m_conf[k] = |(us & ur);
        m_rise[k] = nq & ~m_q[k];
        m_fall[k] = ~nq & m_q[k];
        m_q[k]    = nq;
        if (P_DEB[k] > 0) begin
          for (int i = 0; i < 8; i++) begin
            if (s_len[i] >= P_DEB[k] && s_val[i] != m_fs[k][i]) m_fs[k][i] = s_val[i];
            if (r_len[i] >= P_DEB[k] && r_val[i] != m_fr[k][i]) m_fr[k][i] = r_val[i];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #2;
    if (m_valid) begin
      for (int k = 0; k < NI; k++) begin
        chk("Q",        k, q_w[k],    m_q[k]);
        chk("Qn",       k, qn_w[k],   ~m_q[k]);
        chk("rise",     k, rise_w[k], m_rise[k]);
        chk("fall",     k, fall_w[k], m_fall[k]);
        chk("conflict", k, {7'b0, conf_w[k]}, {7'b0, m_conf[k]});
        chk("cnt",      k, cnt_w[k],  8'(m_cnt[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [7:0] s, input logic [7:0] r, input logic c,
                      input logic rs);
    @(negedge clk);
    S = s; R = r; clr_cnt = c; rst = rs;
    @(posedge clk);
    #3;
  endtask

  logic [7:0] exp_tq [4] = '{8'h02, 8'h00, 8'h02, 8'h00};
  logic [7:0] exp_tc [4] = '{8'h00, 8'h01, 8'h02, 8'h03};

  initial begin
    step(8'h00, 8'h00, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    chk("lit_rst_Q",   0, q_w[0],  8'h00);
    chk("lit_rst_Qn",  0, qn_w[0], 8'hFF);
    chk("lit_rst_cnt", 1, cnt_w[1], 8'h00);

    // Set on channel 0 appears on the DEB+1-th edge.
    step(8'h01, 8'h00, 1'b0, 1'b0);
    chk("lit_set_e1", 0, q_w[0], 8'h00);
    step(8'h01, 8'h00, 1'b0, 1'b0);
    chk("lit_set_e2", 0, q_w[0], 8'h00);
    step(8'h01, 8'h00, 1'b0, 1'b0);
    chk("lit_set_Q",    0, q_w[0],    8'h01);
    chk("lit_set_rise", 0, rise_w[0], 8'h01);
    chk("lit_set_Qn",   0, qn_w[0],   8'hFE);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0);
    chk("lit_hold", 0, q_w[0], 8'h01);

    // Single-cycle glitch ignored; filter count restarts after it.
    step(8'h08, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h08, 8'h00, 1'b0, 1'b0);
    step(8'h08, 8'h00, 1'b0, 1'b0);
    chk("lit_glitch_Q",    0, q_w[0],    8'h01);
    chk("lit_glitch_rise", 0, rise_w[0], 8'h00);
    step(8'h08, 8'h00, 1'b0, 1'b0);
    chk("lit_glitch_set", 0, q_w[0], 8'h09);

    // Toggle under S&R, unfiltered, 2-bit counter.
    step(8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'h02, 8'h02, 1'b0, 1'b0);
      chk("lit_tog_Q",    1, q_w[1],    exp_tq[i]);
      chk("lit_tog_rise", 1, rise_w[1], exp_tq[i]);
      chk("lit_tog_fall", 1, fall_w[1], exp_tq[i] ^ 8'h02);
      chk("lit_tog_conf", 1, {7'b0, conf_w[1]}, 8'h01);
      chk("lit_tog_cnt",  1, cnt_w[1],  exp_tc[i]);
    end
    step(8'h02, 8'h02, 1'b0, 1'b0);
    step(8'h02, 8'h02, 1'b0, 1'b0);
    chk("lit_sat_cnt", 1, cnt_w[1], 8'h03);
    step(8'h02, 8'h02, 1'b1, 1'b0);
    chk("lit_clr_cnt", 1, cnt_w[1], 8'h00);

    // Reset-dominant: S&R keeps 0, releasing R sets all channels.
    step(8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("lit_rdom_hold", 2, q_w[2], 8'h00);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_rdom_e1", 2, q_w[2], 8'h00);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_rdom_e2", 2, q_w[2], 8'h00);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_rdom_Q",    2, q_w[2],    8'hFF);
    chk("lit_rdom_rise", 2, rise_w[2], 8'hFF);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_rdom_Q2",    2, q_w[2],    8'hFF);
    chk("lit_rdom_rise2", 2, rise_w[2], 8'h00);

    // Reset mid-debounce discards progress.
    step(8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'hA5, 8'h00, 1'b0, 1'b0);
    chk("lit_A5", 0, q_w[0], 8'hA5);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    step(8'hFF, 8'h00, 1'b1, 1'b1);
    chk("lit_mrst_Q",   0, q_w[0],   8'h00);
    chk("lit_mrst_Qn",  0, qn_w[0],  8'hFF);
    chk("lit_mrst_cnt", 0, cnt_w[0], 8'h00);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_mrst_e1", 0, q_w[0], 8'h00);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_mrst_e2", 0, q_w[0], 8'h00);
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lit_mrst_e3", 0, q_w[0], 8'hFF);

    // Random traffic: slowly changing levels so filters sometimes pass.
    for (int n = 0; n < 3000; n++) begin
      step(S ^ 8'($urandom & $urandom), R ^ 8'($urandom & $urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
